fifo_sync: RTL and testbench

FIFO_SYNC -- requirements
Module: fifo_sync

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_sync_mem.sv | 28 ++
 rtl/fifo_sync.sv | 125 ++++++++++++
 tb/tb_fifo_sync.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Smallest r with 2**r >= n; used for pointer and occupancy widths.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// FIFO word storage: one synchronous write port, one combinational read port.
module fifo_sync_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // Contents are deliberately never reset; the pointers define what is live.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags
// and a choice of registered or first-word-fall-through read.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = MODE_STD,
  localparam int CW           = clog2(DEPTH + 1),
  localparam int AW           = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  put,
  input  logic                  get,
  input  logic                  clear_err,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty_bar,
  output logic                  full_bar,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPT_C = CW'(AEMPTY_THRESH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] head;

  fifo_sync_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (wr_acc),
    .waddr_i(wptr_q),
    .wdata_i(data_in),
    .raddr_i(rptr_q),
    .rdata_o(head)
  );

  // A write into a full FIFO is still accepted when a read frees a slot in
  // the same cycle; a read of an empty FIFO is never satisfied by the write.
  always_comb begin
    rd_acc  = !reset && get && (count_q != '0);
    wr_acc  = !reset && put && ((count_q != DEPTH_C) || rd_acc);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) begin
      wptr_d = (wptr_q == LAST_C) ? '0 : wptr_q + 1'b1;
    end
    if (rd_acc) begin
      rptr_d = (rptr_q == LAST_C) ? '0 : rptr_q + 1'b1;
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end
    ovf_d = (put && !wr_acc) || (ovf_q && !clear_err);
    unf_d = (get && !rd_acc) || (unf_q && !clear_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      // Head word shown directly; forced to zero while nothing is stored.
      assign data_out   = (count_q != '0) ? head : '0;
      assign data_valid = (count_q != '0);
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dvalid_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          dout_q   <= '0;
          dvalid_q <= 1'b0;
        end else begin
          dvalid_q <= rd_acc;
          if (rd_acc) begin
            dout_q <= head;
          end
        end
      end
      assign data_out   = dout_q;
      assign data_valid = dvalid_q;
    end
  endgenerate

  assign count        = count_q;
  assign empty_bar    = (count_q != '0);
  assign full_bar     = (count_q != DEPTH_C);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPT_C);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: three instances (16 std, 5 std, 8 FWFT) checked every
// cycle against a queue-based model, plus directed scenario checks.
module tb_fifo_sync;

  localparam int DEP [3] = '{16, 5, 8};
  localparam int AFT [3] = '{14, 3, 6};
  localparam int FW  [3] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic       rst [3];
  logic       put [3];
  logic       get [3];
  logic       clr [3];
  logic [7:0] din [3];
  logic [7:0] dout [3];
  logic       dv [3], eb [3], fb [3], af [3], ae [3], ov [3], un [3];
  logic [4:0] cnt0;
  logic [2:0] cnt1;
  logic [3:0] cnt2;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq [3][$];
  logic [7:0] m_dout [3];
  logic       m_dv [3], m_ov [3], m_un [3];

  always #5 clk = ~clk;

  fifo_sync #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_d16 (
    .clk(clk), .reset(rst[0]), .put(put[0]), .get(get[0]), .clear_err(clr[0]),
    .data_in(din[0]), .data_out(dout[0]), .data_valid(dv[0]), .empty_bar(eb[0]),
    .full_bar(fb[0]), .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt0),
    .overflow(ov[0]), .underflow(un[0]));

  fifo_sync #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_d5 (
    .clk(clk), .reset(rst[1]), .put(put[1]), .get(get[1]), .clear_err(clr[1]),
    .data_in(din[1]), .data_out(dout[1]), .data_valid(dv[1]), .empty_bar(eb[1]),
    .full_bar(fb[1]), .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt1),
    .overflow(ov[1]), .underflow(un[1]));

  fifo_sync #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1)) u_fw (
    .clk(clk), .reset(rst[2]), .put(put[2]), .get(get[2]), .clear_err(clr[2]),
    .data_in(din[2]), .data_out(dout[2]), .data_valid(dv[2]), .empty_bar(eb[2]),
    .full_bar(fb[2]), .almost_full(af[2]), .almost_empty(ae[2]), .count(cnt2),
    .overflow(ov[2]), .underflow(un[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    if (i == 0) return 32'(cnt0);
    if (i == 1) return 32'(cnt1);
    return 32'(cnt2);
  endfunction

  // Apply one clock edge of the reference behaviour using the current inputs.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        mq[i].delete();
        m_dout[i] = 8'h00;
        m_dv[i]   = 1'b0;
        m_ov[i]   = 1'b0;
        m_un[i]   = 1'b0;
      end else begin
        int   n;
        logic rd, wr;
        logic [7:0] v;
        n  = mq[i].size();
        rd = get[i] && (n > 0);
        wr = put[i] && ((n < DEP[i]) || rd);
        if (FW[i] == 0) m_dv[i] = rd;
        if (rd) begin
          v = mq[i].pop_front();
          if (FW[i] == 0) m_dout[i] = v;
        end
        if (wr) mq[i].push_back(din[i]);
        m_ov[i] = (put[i] && !wr) || (m_ov[i] && !clr[i]);
        m_un[i] = (get[i] && !rd) || (m_un[i] && !clr[i]);
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int n;
      n = mq[i].size();
      chk($sformatf("count[%0d]", i), cnt_of(i), 32'(n));
      chk($sformatf("empty_bar[%0d]", i), 32'(eb[i]), 32'(n != 0));
      chk($sformatf("full_bar[%0d]", i), 32'(fb[i]), 32'(n != DEP[i]));
      chk($sformatf("almost_full[%0d]", i), 32'(af[i]), 32'(n >= AFT[i]));
      chk($sformatf("almost_empty[%0d]", i), 32'(ae[i]), 32'(n <= 2));
      chk($sformatf("overflow[%0d]", i), 32'(ov[i]), 32'(m_ov[i]));
      chk($sformatf("underflow[%0d]", i), 32'(un[i]), 32'(m_un[i]));
      if (FW[i] == 1) begin
        chk($sformatf("data_valid[%0d]", i), 32'(dv[i]), 32'(n != 0));
        if (n > 0) chk($sformatf("data_out[%0d]", i), 32'(dout[i]), 32'(mq[i][0]));
      end else begin
        chk($sformatf("data_valid[%0d]", i), 32'(dv[i]), 32'(m_dv[i]));
        chk($sformatf("data_out[%0d]", i), 32'(dout[i]), 32'(m_dout[i]));
      end
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0;
      put[i] = 1'b0;
      get[i] = 1'b0;
      clr[i] = 1'b0;
      din[i] = 8'h00;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    step();
    chk("reset_empty_bar", 32'(eb[0]), 32'd0);
    chk("reset_full_bar", 32'(fb[0]), 32'd1);

    // Fill the 16-deep instance with 0x00..0x0F, then one put too many.
    for (int k = 0; k < 16; k++) begin
      put[0] = 1'b1; din[0] = 8'(k);
      step();
    end
    chk("fill_count", cnt_of(0), 32'd16);
    chk("fill_full_bar", 32'(fb[0]), 32'd0);
    chk("fill_almost_full", 32'(af[0]), 32'd1);
    put[0] = 1'b1; din[0] = 8'hEE;
    step();
    chk("fill_overflow", 32'(ov[0]), 32'd1);

    // Drain with an idle cycle between reads so each valid pulse is visible.
    for (int k = 0; k < 16; k++) begin
      get[0] = 1'b1;
      step();
      chk($sformatf("drain_data_%0d", k), 32'(dout[0]), 32'(k));
      chk($sformatf("drain_valid_%0d", k), 32'(dv[0]), 32'd1);
      step();
    end
    get[0] = 1'b1;
    step();
    chk("drain_underflow", 32'(un[0]), 32'd1);
    chk("drain_hold", 32'(dout[0]), 32'h0F);

    // Simultaneous put+get when full, then when empty.
    clr[0] = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      put[0] = 1'b1; din[0] = 8'($urandom);
      step();
    end
    put[0] = 1'b1; get[0] = 1'b1; din[0] = 8'h5A;
    step();
    chk("both_full_count", cnt_of(0), 32'd16);
    chk("both_full_full_bar", 32'(fb[0]), 32'd0);
    for (int k = 0; k < 16; k++) begin
      get[0] = 1'b1;
      step();
    end
    put[0] = 1'b1; get[0] = 1'b1; din[0] = 8'h77;
    step();
    chk("both_empty_count", cnt_of(0), 32'd1);
    chk("both_empty_underflow", 32'(un[0]), 32'd1);

    // Reset with seven words stored.
    for (int k = 0; k < 6; k++) begin
      put[0] = 1'b1; din[0] = 8'(8'h40 + k);
      step();
    end
    chk("pre_reset_count", cnt_of(0), 32'd7);
    rst[0] = 1'b1; put[0] = 1'b1; din[0] = 8'h99;
    step();
    chk("post_reset_count", cnt_of(0), 32'd0);
    chk("post_reset_empty_bar", 32'(eb[0]), 32'd0);

    // clear_err in the same cycle as a fresh overflow leaves the flag set.
    for (int k = 0; k < 17; k++) begin
      put[0] = 1'b1; din[0] = 8'(k);
      step();
    end
    put[0] = 1'b1; clr[0] = 1'b1;
    step();
    chk("clear_vs_overflow", 32'(ov[0]), 32'd1);
    clr[0] = 1'b1;
    step();
    chk("clear_alone", 32'(ov[0]), 32'd0);

    // Depth-5 instance: 12 words streamed through, wrapping the pointers.
    put[1] = 1'b1; din[1] = 8'h30;
    step();
    for (int k = 1; k < 12; k++) begin
      put[1] = 1'b1; get[1] = 1'b1; din[1] = 8'(8'h30 + k);
      step();
      chk($sformatf("wrap_data_%0d", k - 1), 32'(dout[1]), 32'(8'h30 + k - 1));
    end
    get[1] = 1'b1;
    step();
    chk("wrap_data_11", 32'(dout[1]), 32'h3B);

    // FWFT instance: word written into empty appears the next cycle.
    put[2] = 1'b1; din[2] = 8'hA5;
    step();
    chk("fwft_data", 32'(dout[2]), 32'hA5);
    chk("fwft_valid", 32'(dv[2]), 32'd1);
    get[2] = 1'b1;
    step();
    chk("fwft_pop_valid", 32'(dv[2]), 32'd0);

    // Randomised traffic on all three, alternating fill-biased and drain-biased windows.
    for (int c = 0; c < 400; c++) begin
      int pp;
      pp = ((c / 50) % 2 == 0) ? 70 : 30;
      for (int i = 0; i < 3; i++) begin
        rst[i] = ($urandom_range(63) == 0);
        put[i] = ($urandom_range(99) < pp);
        get[i] = ($urandom_range(99) < (100 - pp));
        clr[i] = ($urandom_range(7) == 0);
        din[i] = 8'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
